// File: rtl/instruction_decode.sv
// MIPS ID stage: GPR file with write-through bypass, instruction decode to ALU op/operands,
// and the ID/EX pipeline register with stall and flush.
module instruction_decode #(
  parameter int NB_DATA  = 32,
  parameter int NB_OP    = 6,
  parameter int NB_ADDR  = 5,
  parameter int NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic [NB_DATA-1:0]  i_pc4,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_wb_write,
  input  logic [NB_ADDR-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0]  i_wb_data,
  output logic                o_valid,
  output logic [NB_OP-1:0]    o_alu_op,
  output logic [NB_DATA-1:0]  o_data_A,
  output logic [NB_DATA-1:0]  o_data_B,
  output logic [4:0]          o_shamt,
  output logic [NB_ADDR-1:0]  o_rd_addr,
  output logic                o_reg_write
);

  localparam int NREG = 2 ** NB_ADDR;
  localparam logic [NB_OP-1:0] OP_IDLE = {NB_OP{1'b1}};

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;

  // Instruction fields
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [NB_ADDR-1:0] rs_addr;
  logic [NB_ADDR-1:0] rt_addr;
  logic [NB_ADDR-1:0] rd_field;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] imm_se;
  logic [NB_DATA-1:0] imm_ze;

  assign opcode   = i_instr[31:26];
  assign funct    = i_instr[5:0];
  assign rs_addr  = i_instr[21 +: NB_ADDR];
  assign rt_addr  = i_instr[16 +: NB_ADDR];
  assign rd_field = i_instr[11 +: NB_ADDR];
  assign imm      = i_instr[15:0];
  assign imm_se   = {{(NB_DATA-16){imm[15]}}, imm};
  assign imm_ze   = {{(NB_DATA-16){1'b0}}, imm};

  // GPR file; entry 0 is never written so it stays zero after reset
  logic [NB_DATA-1:0] gpr_q [NREG];
  logic               wb_en;

  assign wb_en = i_wb_write && (i_wb_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wb_en) begin
      gpr_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Read ports see a same-cycle WB write so no extra forwarding is needed
  logic [NB_DATA-1:0] rs_val;
  logic [NB_DATA-1:0] rt_val;

  assign rs_val = (rs_addr == '0) ? '0 :
                  (wb_en && rs_addr == i_wb_addr) ? i_wb_data : gpr_q[rs_addr];
  assign rt_val = (rt_addr == '0) ? '0 :
                  (wb_en && rt_addr == i_wb_addr) ? i_wb_data : gpr_q[rt_addr];

  logic alu_funct;
  assign alu_funct = funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b1001??,
                                   6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b0001??};

  // Decoded next-state for the ID/EX register
  logic [NB_OP-1:0]   op_d;
  logic [NB_DATA-1:0] a_d;
  logic [NB_DATA-1:0] b_d;
  logic [4:0]         shamt_d;
  logic [NB_ADDR-1:0] rd_d;
  logic               rw_d;
  logic               known;

  always_comb begin
    op_d    = OP_IDLE;
    a_d     = '0;
    b_d     = '0;
    shamt_d = '0;
    rd_d    = '0;
    rw_d    = 1'b0;
    known   = 1'b0;
    if (i_valid) begin
      case (opcode)
        OPC_RTYPE: begin
          if (alu_funct) begin
            known = 1'b1;
            op_d  = NB_OP'(funct);
            a_d   = rs_val;
            b_d   = rt_val;
            rd_d  = rd_field;
            rw_d  = 1'b1;
          end else if (funct == FN_JALR) begin
            known = 1'b1;
            op_d  = NB_OP'(FN_JALR);
            a_d   = i_pc4;
            rd_d  = rd_field;
            rw_d  = 1'b1;
          end
        end
        OPC_ADDI, OPC_SLTI: begin
          known = 1'b1;
          op_d  = NB_OP'(opcode);
          a_d   = rs_val;
          b_d   = imm_se;
          rd_d  = rt_addr;
          rw_d  = 1'b1;
        end
        OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
          known = 1'b1;
          op_d  = NB_OP'(opcode);
          a_d   = rs_val;
          b_d   = imm_ze;
          rd_d  = rt_addr;
          rw_d  = 1'b1;
        end
        OPC_ADDIU: begin
          known = 1'b1;
          op_d  = NB_OP'(FN_ADDU);
          a_d   = rs_val;
          b_d   = imm_se;
          rd_d  = rt_addr;
          rw_d  = 1'b1;
        end
        OPC_LW: begin
          known = 1'b1;
          op_d  = NB_OP'(FN_ADD);
          a_d   = rs_val;
          b_d   = imm_se;
          rd_d  = rt_addr;
          rw_d  = 1'b1;
        end
        OPC_SW: begin
          // Store computes its address but writes no register
          known = 1'b1;
          op_d  = NB_OP'(FN_ADD);
          a_d   = rs_val;
          b_d   = imm_se;
        end
        default: ;
      endcase
      if (known) begin
        shamt_d = i_instr[10:6];
      end
    end
  end

  // ID/EX register: reset > flush > stall > load
  logic               valid_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [4:0]         shamt_q;
  logic [NB_ADDR-1:0] rd_q;
  logic               rw_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      valid_q <= 1'b0;
      op_q    <= OP_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else if (!i_stall) begin
      valid_q <= i_valid;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shamt_q <= shamt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_op    = op_q;
  assign o_data_A    = a_q;
  assign o_data_B    = b_q;
  assign o_shamt     = shamt_q;
  assign o_rd_addr   = rd_q;
  assign o_reg_write = rw_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a table-driven model of the ID stage.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset, valid, stall, flush, wb_write;
  logic [31:0] instr, pc4, wb_data;
  logic [4:0]  wb_addr;
  logic        o_valid, o_reg_write;
  logic [5:0]  o_alu_op;
  logic [31:0] o_data_A, o_data_B;
  logic [4:0]  o_shamt, o_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_instr(instr), .i_pc4(pc4),
    .i_stall(stall), .i_flush(flush), .i_wb_write(wb_write), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .o_valid(o_valid), .o_alu_op(o_alu_op), .o_data_A(o_data_A),
    .o_data_B(o_data_B), .o_shamt(o_shamt), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write)
  );

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  logic [31:0] gpr [32];
  ent_t        exp_e;
  bit          started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ent_t bubble(input logic v);
    ent_t e;
    e.v = v; e.op = 6'h3F; e.a = 0; e.b = 0; e.sh = 0; e.rd = 0; e.rw = 0;
    return e;
  endfunction

  // Register read as seen by ID: r0 is zero, a same-cycle WB write is visible
  function automatic logic [31:0] rd_gpr(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_write && wb_addr == a) return wb_data;
    return gpr[a];
  endfunction

  function automatic ent_t model_decode();
    ent_t        e;
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rdf;
    logic [15:0] im;
    logic [31:0] se, ze;
    e   = bubble(valid);
    if (!valid) return e;
    opc = instr[31:26]; fn = instr[5:0];
    rs  = instr[25:21]; rt = instr[20:16]; rdf = instr[15:11]; im = instr[15:0];
    se  = 32'($signed(im));
    ze  = 32'(im);
    if (opc == 0) begin
      if (fn inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                     6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) begin
        e.op = fn; e.a = rd_gpr(rs); e.b = rd_gpr(rt); e.rd = rdf; e.rw = 1;
      end else if (fn == 6'd9) begin
        e.op = 6'd9; e.a = pc4; e.b = 0; e.rd = rdf; e.rw = 1;
      end else return e;
    end else if (opc == 6'd8 || opc == 6'd10) begin
      e.op = opc; e.a = rd_gpr(rs); e.b = se; e.rd = rt; e.rw = 1;
    end else if (opc >= 6'd12 && opc <= 6'd15) begin
      e.op = opc; e.a = rd_gpr(rs); e.b = ze; e.rd = rt; e.rw = 1;
    end else if (opc == 6'd9) begin
      e.op = 6'd33; e.a = rd_gpr(rs); e.b = se; e.rd = rt; e.rw = 1;
    end else if (opc == 6'd35) begin
      e.op = 6'd32; e.a = rd_gpr(rs); e.b = se; e.rd = rt; e.rw = 1;
    end else if (opc == 6'd43) begin
      e.op = 6'd32; e.a = rd_gpr(rs); e.b = se; e.rd = 0; e.rw = 0;
    end else return e;
    e.sh = instr[10:6];
    return e;
  endfunction

  // Reference model: advances on every rising edge from the inputs held across it
  always @(posedge clk) begin
    if (reset) begin
      exp_e = bubble(1'b0);
      for (int i = 0; i < 32; i++) gpr[i] = 0;
    end else begin
      if (flush) exp_e = bubble(1'b0);
      else if (!stall) exp_e = model_decode();
      if (wb_write && wb_addr != 0) gpr[wb_addr] = wb_data;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(o_valid), 32'(exp_e.v));
      chk("alu_op", 32'(o_alu_op), 32'(exp_e.op));
      chk("data_A", o_data_A, exp_e.a);
      chk("data_B", o_data_B, exp_e.b);
      chk("shamt", 32'(o_shamt), 32'(exp_e.sh));
      chk("rd_addr", 32'(o_rd_addr), 32'(exp_e.rd));
      chk("reg_write", 32'(o_reg_write), 32'(exp_e.rw));
    end
  end

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int im);
    return {6'(op), 5'(rs), 5'(rt), 16'(im)};
  endfunction

  task automatic idle();
    reset = 0; valid = 0; instr = 0; pc4 = 0; stall = 0; flush = 0;
    wb_write = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    valid = 1; instr = ins;
  endtask

  task automatic wb(input int a, input logic [31:0] d);
    wb_write = 1; wb_addr = 5'(a); wb_data = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [5:0]  fns [18];
    logic [5:0]  ops [10];
    fns = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
            6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9, 6'd1};
    ops = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd56};
    k   = $urandom_range(0, 9);
    if (k < 4)
      return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                   $urandom_range(0, 31), fns[$urandom_range(0, 17)]);
    if (k < 8)
      return itype(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 31),
                   $urandom_range(0, 65535));
    if (k == 8) return $urandom;
    return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 63));
  endfunction

  initial begin
    idle();
    // Reset beats a valid instruction
    reset = 1; issue(rtype(1, 2, 3, 0, 6'b100000));
    tick();
    chk("t1_valid", 32'(o_valid), 0);
    chk("t1_op", 32'(o_alu_op), 32'h3F);
    chk("t1_A", o_data_A, 0);
    chk("t1_B", o_data_B, 0);
    chk("t1_rw", 32'(o_reg_write), 0);

    idle(); wb(1, 5); tick();
    idle(); wb(2, 3); tick();
    idle(); issue(rtype(1, 2, 3, 0, 6'b100000)); tick();
    chk("t2_op", 32'(o_alu_op), 32'h20);
    chk("t2_A", o_data_A, 5);
    chk("t2_B", o_data_B, 3);
    chk("t2_rd", 32'(o_rd_addr), 3);
    chk("t2_rw", 32'(o_reg_write), 1);

    idle(); issue(itype(6'b001000, 1, 4, 16'hFFFF)); tick();
    chk("t3_addi_B", o_data_B, 32'hFFFF_FFFF);
    chk("t3_addi_rd", 32'(o_rd_addr), 4);
    idle(); issue(itype(6'b001101, 1, 4, 16'hFFFF)); tick();
    chk("t3_ori_B", o_data_B, 32'h0000_FFFF);
    chk("t3_ori_op", 32'(o_alu_op), 32'h0D);

    idle(); wb(7, 32'hDEAD); issue(rtype(7, 1, 5, 0, 6'b100010)); tick();
    chk("t4_bypass_A", o_data_A, 32'hDEAD);
    chk("t4_sub_op", 32'(o_alu_op), 32'h22);
    idle(); wb(0, 9); issue(rtype(0, 0, 6, 0, 6'b100000)); tick();
    chk("t4_r0_same", o_data_A, 0);
    idle(); issue(rtype(0, 7, 6, 0, 6'b100000)); tick();
    chk("t4_r0_later", o_data_A, 0);
    chk("t4_r7_B", o_data_B, 32'hDEAD);

    idle(); issue(rtype(1, 2, 3, 4, 6'b100000)); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; issue(rand_instr()); if (i == 0) wb(1, 77); tick();
      chk("t5_hold_op", 32'(o_alu_op), 32'h20);
      chk("t5_hold_A", o_data_A, 5);
      chk("t5_hold_sh", 32'(o_shamt), 4);
    end
    idle(); stall = 1; flush = 1; issue(rtype(1, 2, 3, 0, 6'b100000)); tick();
    chk("t5_flush_valid", 32'(o_valid), 0);
    chk("t5_flush_op", 32'(o_alu_op), 32'h3F);
    idle(); issue(rtype(1, 2, 3, 0, 6'b100000)); tick();
    chk("t5_wb_in_stall", o_data_A, 77);

    idle(); pc4 = 32'h100; issue(rtype(1, 0, 31, 0, 6'b001001)); tick();
    chk("t6_jalr_op", 32'(o_alu_op), 32'h09);
    chk("t6_jalr_A", o_data_A, 32'h100);
    chk("t6_jalr_rd", 32'(o_rd_addr), 31);
    idle(); issue(itype(6'b111000, 1, 2, 16'h1234)); tick();
    chk("t6_unk_op", 32'(o_alu_op), 32'h3F);
    chk("t6_unk_rw", 32'(o_reg_write), 0);
    chk("t6_unk_valid", 32'(o_valid), 1);
    idle(); issue(rtype(1, 0, 0, 0, 6'b001000)); tick();
    chk("t6_jr_op", 32'(o_alu_op), 32'h3F);
    idle(); issue(itype(6'b101011, 1, 9, 16'h8000)); tick();
    chk("t6_sw_rw", 32'(o_reg_write), 0);
    chk("t6_sw_B", o_data_B, 32'hFFFF_8000);
    idle(); tick();
    chk("t6_invalid_valid", 32'(o_valid), 0);

    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 8);
      valid = ($urandom_range(0, 99) < 85);
      instr = rand_instr();
      pc4   = $urandom;
      if ($urandom_range(0, 99) < 60) wb($urandom_range(0, 7), $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
